coverage_stall_monitor: RTL and testbench
=========================================

# coverage_stall_monitor

Parametrised stall and watchdog monitor for fuzzing runs. It watches the DUT coverage-summary bus and the `tohost` word. It raises an interrupt toward the core's software-interrupt input when coverage stops changing for a coverage-scaled number of cycles, or when no test completion occurs within a fixed window. Compared with the single-threshold monitor it adds an enable, an acknowledge handshake, a cause code, a post-fire holdoff and saturating statistics. It sits in the testbench between `io_covSum`/`tohost` and the forced `io_interrupts_msip`.

## Interface
Parameters:
- `COV_W`, 30: coverage-summary width.
- `SCALE_LSB`, 19: right shift applied to `cov` to form the threshold multiplier.
- `BASE_WAIT`, 1000: stall cycles per multiplier step.
- `WDOG_LIMIT`, 50000: cycles without `tohost[0]` before the watchdog fires.
- `CNT_W`, 32: width of the stall counter, watchdog counter and threshold.
- `HOLDOFF`, 16: cycles spent in HOLD after an acknowledge.

Ports:
- `clock` in 1: the only clock; all logic is on the posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: monitor armed.
- `cov` in COV_W: coverage summary.
- `tohost` in 64: bit 0 signals test completion.
- `irq_ack` in 1: interrupt acknowledge, level-sampled.
- `interrupt` out 1: registered interrupt request.
- `irq_cause` out 2: 01 = stall, 10 = watchdog, 11 = both; latched while `interrupt` is high.
- `fire_count` out 16: number of FIRE entries; saturates at 16'hFFFF.
- `stall_count` out CNT_W: current stall counter, for debug.

## Operation
- Threshold: `thr = BASE_WAIT * ((cov >> SCALE_LSB) + 1)`.
  - Computed at CNT_W+COV_W bits.
  - Saturates to all-ones of CNT_W when the result exceeds CNT_W.
- Registers: `state`, `pre_cov`, `stall_cnt`, `wdog_cnt`, `hold_cnt`, `fire_count`, `irq_cause`.
- States:
  - IDLE
    - Counters are held at 0 and `interrupt` is 0.
    - When `enable`=1: load `pre_cov<=cov`, go to RUN.
  - RUN, each cycle:
    - If `cov!=pre_cov`: `pre_cov<=cov`, `stall_cnt<=0`. Otherwise `stall_cnt` increments, saturating.
    - If `tohost[0]`: `stall_cnt<=0` (overrides the two rules above) and `wdog_cnt<=0`. Otherwise `wdog_cnt` increments, saturating.
    - `f_stall = (stall_cnt>=thr) && (cov==pre_cov)`, evaluated on registered counters.
    - `f_wdog = wdog_cnt>=WDOG_LIMIT`.
    - If `(f_stall||f_wdog) && !tohost[0]`:
      - go to FIRE;
      - `irq_cause<={f_wdog,f_stall}`;
      - `fire_count` increments (saturating).
  - FIRE
    - `interrupt`=1; counters are frozen.
    - When `irq_ack`=1: go to HOLD with `stall_cnt`, `wdog_cnt` and `hold_cnt` cleared.
  - HOLD
    - `interrupt`=0; `hold_cnt` increments.
    - When `hold_cnt==HOLDOFF-1`: load `pre_cov<=cov`, go to RUN.
- `enable`=0 in any state: go to IDLE on the next edge and clear all counters except `fire_count`.
- `irq_cause` is cleared to 00 on entry to IDLE or HOLD.

## Timing
- Reset, and reset mid-operation:
  - `state`=IDLE;
  - `interrupt`=0, `irq_cause`=00, `fire_count`=0, `stall_count`=0;
  - `pre_cov`, `wdog_cnt` and `hold_cnt` = 0.
  - Reset overrides every other input on the same edge.
- `interrupt` is a direct state decode (FIRE), so it is registered and glitch-free.
- Latency from fire condition to interrupt:
  - A fire condition true in cycle t gives `interrupt`=1 in cycle t+1.
  - The k-th RUN cycle (0-indexed, from entry) has `stall_cnt`=k under constant `cov`.
- Acknowledge timing:
  - `irq_ack` high in FIRE cycle t gives `interrupt`=0 at t+1.
  - RUN resumes at t+1+HOLDOFF.
  - `irq_ack` outside FIRE is ignored.
- Simultaneous events:
  - `tohost[0]` together with a fire condition: no fire, both counters cleared.
  - `cov` change together with `stall_cnt>=thr`: no stall fire; the watchdog is still evaluated.
  - `enable` falling together with `irq_ack`: IDLE wins.
- Counters never wrap; they saturate at all-ones.

## Test plan
- Basic stall: `cov`=0, `enable`=1, no `tohost` -> `interrupt` rises 1001 cycles after RUN entry with `irq_cause`=01 and `fire_count`=1.
- Scaled threshold: `cov`=3<<19 held constant -> fire at RUN cycle 4000, `interrupt` at 4001.
- Watchdog: `cov` increments every cycle, `tohost`=0 -> `interrupt` at RUN cycle 50001 with `irq_cause`=10. Pulsing `tohost[0]` every 40000 cycles -> never fires.
- Handshake and holdoff: `irq_ack` pulsed 5 cycles after the rise -> `interrupt` falls the next cycle, RUN re-entered 16 cycles later, second fire 1001 cycles after that, `fire_count`=2.
- Boundary: `tohost[0]` asserted exactly in the fire cycle -> no interrupt, counters 0. Constant `cov` changing in the fire cycle -> no stall fire.
- Saturation and reset: with CNT_W=16, `cov`=all-ones -> `thr`=65535 and `stall_cnt` holds at 65535 before firing. `reset` asserted in FIRE -> next cycle `interrupt`=0 and `fire_count`=0.

Source files
------------

// File: rtl/coverage_stall_monitor.sv
// coverage_stall_monitor
//
// Purpose: watches a coverage-summary bus and the tohost completion word during
// fuzzing runs. It requests a software interrupt when coverage stays unchanged
// for a coverage-scaled number of cycles (stall) or when no test completes
// within a fixed window (watchdog). An acknowledge moves the monitor into a
// short holdoff before it re-arms.
//
// Handshake: interrupt is a level request that stays high while the monitor is
// in FIRE. It is released on the edge after irq_ack is sampled high in FIRE.
// irq_ack is ignored in every other state.
//
// Ports:
//   clock        in   sole clock, posedge
//   reset        in   synchronous, active-high
//   enable       in   monitor armed; low returns to IDLE on the next edge
//   cov          in   coverage summary [COV_W]
//   tohost       in   bit 0 signals test completion [64]
//   irq_ack      in   interrupt acknowledge, level-sampled
//   interrupt    out  registered interrupt request (state == FIRE)
//   irq_cause    out  01 stall, 10 watchdog, 11 both; 00 when not firing
//   fire_count   out  number of FIRE entries, saturating [16]
//   stall_count  out  current stall counter [CNT_W]
//   dbg_state    out  FSM state: 0 IDLE, 1 RUN, 2 FIRE, 3 HOLD
module coverage_stall_monitor #(
   parameter int COV_W      = 30,
   parameter int SCALE_LSB  = 19,
   parameter int BASE_WAIT  = 1000,
   parameter int WDOG_LIMIT = 50000,
   parameter int CNT_W      = 32,
   parameter int HOLDOFF    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [COV_W-1:0] cov,
   input  logic [63:0]      tohost,
   input  logic             irq_ack,
   output logic             interrupt,
   output logic [1:0]       irq_cause,
   output logic [15:0]      fire_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIRE = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   localparam int PW     = CNT_W + COV_W;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
   localparam logic [CNT_W-1:0]  WDOG_C    = CNT_W'(WDOG_LIMIT);

   state_e              state_q, state_d;
   logic [COV_W-1:0]    pre_cov_q, pre_cov_d;
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic [CNT_W-1:0]    wdog_q, wdog_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [15:0]         fire_q, fire_d;
   logic [1:0]          cause_q, cause_d;

   logic [PW-1:0]       mult, prod;
   logic [CNT_W-1:0]    thr;
   logic                f_stall, f_wdog;
   logic                unused_tohost;

   assign unused_tohost = ^tohost[63:1];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Threshold is formed at full product width so a large coverage value
   // clamps to the counter maximum instead of wrapping to a small threshold.
   always_comb begin
      mult = PW'(cov >> SCALE_LSB) + PW'(1);
      prod = PW'(BASE_WAIT) * mult;
      thr  = (|prod[PW-1:CNT_W]) ? '1 : prod[CNT_W-1:0];
   end

   // A coverage change in the same cycle suppresses the stall fire.
   assign f_stall = (stall_q >= thr) && (cov == pre_cov_q);
   assign f_wdog  = (wdog_q >= WDOG_C);

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         pre_cov_q <= '0;
         stall_q   <= '0;
         wdog_q    <= '0;
         hold_q    <= '0;
         fire_q    <= '0;
         cause_q   <= '0;
      end else begin
         pre_cov_q <= pre_cov_d;
         stall_q   <= stall_d;
         wdog_q    <= wdog_d;
         hold_q    <= hold_d;
         fire_q    <= fire_d;
         cause_q   <= cause_d;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      state_d   = state_q;
      pre_cov_d = pre_cov_q;
      stall_d   = stall_q;
      wdog_d    = wdog_q;
      hold_d    = hold_q;
      fire_d    = fire_q;
      cause_d   = cause_q;

      if (!enable) begin
         // Disarming wins over everything, including a same-cycle acknowledge.
         state_d = S_IDLE;
         stall_d = '0;
         wdog_d  = '0;
         hold_d  = '0;
         cause_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               stall_d   = '0;
               wdog_d    = '0;
               hold_d    = '0;
               cause_d   = '0;
               pre_cov_d = cov;
               state_d   = S_RUN;
            end
            S_RUN: begin
               if (cov != pre_cov_q) begin
                  pre_cov_d = cov;
                  stall_d   = '0;
               end else begin
                  stall_d = sat_inc(stall_q);
               end
               // Test completion restarts both windows and blocks any fire.
               if (tohost[0]) begin
                  stall_d = '0;
                  wdog_d  = '0;
               end else begin
                  wdog_d = sat_inc(wdog_q);
               end
               if ((f_stall || f_wdog) && !tohost[0]) begin
                  state_d = S_FIRE;
                  cause_d = {f_wdog, f_stall};
                  fire_d  = (&fire_q) ? fire_q : fire_q + 16'd1;
               end
            end
            S_FIRE: begin
               if (irq_ack) begin
                  state_d = S_HOLD;
                  stall_d = '0;
                  wdog_d  = '0;
                  hold_d  = '0;
                  cause_d = '0;
               end
            end
            S_HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d    = '0;
                  pre_cov_d = cov;
                  state_d   = S_RUN;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs: all decoded from registers
   always_comb begin
      interrupt   = (state_q == S_FIRE);
      irq_cause   = cause_q;
      fire_count  = fire_q;
      stall_count = stall_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_coverage_stall_monitor.sv
module tb_coverage_stall_monitor;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIRE = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // main instance: default widths, shortened watchdog window
   logic        m_enable = 1'b0;
   logic [29:0] m_cov    = '0;
   logic [63:0] m_tohost = '0;
   logic        m_ack    = 1'b0;
   logic        m_irq;
   logic [1:0]  m_cause;
   logic [15:0] m_fire;
   logic [31:0] m_stall;
   logic [1:0]  m_state;

   // small instance: narrow counters to reach saturation quickly
   logic        s_enable = 1'b0;
   logic [7:0]  s_cov    = '0;
   logic [63:0] s_tohost = '0;
   logic        s_ack    = 1'b0;
   logic        s_irq;
   logic [1:0]  s_cause;
   logic [15:0] s_fire;
   logic [5:0]  s_stall;
   logic [1:0]  s_state;

   coverage_stall_monitor #(
      .COV_W(30), .SCALE_LSB(19), .BASE_WAIT(1000), .WDOG_LIMIT(5000),
      .CNT_W(32), .HOLDOFF(16)
   ) u_main (
      .clock(clock), .reset(reset), .enable(m_enable), .cov(m_cov),
      .tohost(m_tohost), .irq_ack(m_ack), .interrupt(m_irq),
      .irq_cause(m_cause), .fire_count(m_fire), .stall_count(m_stall),
      .dbg_state(m_state)
   );

   // thr = 10 * ((255 >> 2) + 1) = 640, clamps to 63 at 6 bits
   coverage_stall_monitor #(
      .COV_W(8), .SCALE_LSB(2), .BASE_WAIT(10), .WDOG_LIMIT(63),
      .CNT_W(6), .HOLDOFF(4)
   ) u_small (
      .clock(clock), .reset(reset), .enable(s_enable), .cov(s_cov),
      .tohost(s_tohost), .irq_ack(s_ack), .interrupt(s_irq),
      .irq_cause(s_cause), .fire_count(s_fire), .stall_count(s_stall),
      .dbg_state(s_state)
   );

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change and outputs are sampled 1 time unit after each posedge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic m_enter_run(input logic [29:0] c);
      m_cov    = c;
      m_enable = 1'b1;
      step(1);
      chk("run_entry_state", m_state, ST_RUN);
      chk("run_entry_stall", m_stall, 0);
   endtask

   task automatic m_disable();
      m_enable = 1'b0;
      step(1);
      chk("disable_state", m_state, ST_IDLE);
      chk("disable_irq", m_irq, 0);
   endtask

   logic saw_irq;

   initial begin
      #1;
      step(2);
      reset = 1'b0;

      // reset state
      chk("rst_irq", m_irq, 0);
      chk("rst_cause", m_cause, 0);
      chk("rst_fire", m_fire, 0);
      chk("rst_stall", m_stall, 0);
      chk("rst_state", m_state, ST_IDLE);
      chk("rst_s_state", s_state, ST_IDLE);

      // basic stall: RUN cycle 1000 fires, interrupt one cycle later
      m_enter_run(30'd0);
      step(1000);
      chk("basic_pre_irq", m_irq, 0);
      chk("basic_stall_1000", m_stall, 1000);
      step(1);
      chk("basic_irq", m_irq, 1);
      chk("basic_cause", m_cause, 2'b01);
      chk("basic_fire", m_fire, 1);

      // handshake: ack 5 cycles after rise, holdoff 16, refire after 1001
      step(5);
      chk("fire_held", m_irq, 1);
      m_ack = 1'b1;
      step(1);
      m_ack = 1'b0;
      chk("ack_irq_fall", m_irq, 0);
      chk("ack_state_hold", m_state, ST_HOLD);
      chk("ack_cause_clr", m_cause, 0);
      step(15);
      chk("hold_last", m_state, ST_HOLD);
      step(1);
      chk("hold_to_run", m_state, ST_RUN);
      chk("hold_stall_clr", m_stall, 0);
      // ack outside FIRE must have no effect
      m_ack = 1'b1;
      step(1);
      m_ack = 1'b0;
      step(999);
      chk("refire_pre_irq", m_irq, 0);
      step(1);
      chk("refire_irq", m_irq, 1);
      chk("refire_fire", m_fire, 2);

      // enable falling together with ack: IDLE wins
      m_ack = 1'b1;
      m_disable();
      m_ack = 1'b0;
      chk("disable_cause", m_cause, 0);
      chk("disable_fire_kept", m_fire, 2);

      // scaled threshold: cov = 3<<19 -> thr 4000
      m_enter_run(30'd3 << 19);
      step(4000);
      chk("scaled_pre_irq", m_irq, 0);
      chk("scaled_stall", m_stall, 4000);
      step(1);
      chk("scaled_irq", m_irq, 1);
      chk("scaled_cause", m_cause, 2'b01);
      chk("scaled_fire", m_fire, 3);
      m_disable();

      // tohost in the fire cycle: no fire, counters cleared
      m_enter_run(30'd0);
      step(1000);
      m_tohost = 64'd1;
      step(1);
      m_tohost = 64'd0;
      chk("tohost_no_irq", m_irq, 0);
      chk("tohost_stall_clr", m_stall, 0);
      chk("tohost_state", m_state, ST_RUN);
      // coverage change in the fire cycle: no stall fire
      step(1000);
      chk("covchg_stall_1000", m_stall, 1000);
      m_cov = 30'd5;
      step(1);
      chk("covchg_no_irq", m_irq, 0);
      chk("covchg_stall_clr", m_stall, 0);
      step(1000);
      chk("covchg_pre_irq", m_irq, 0);
      step(1);
      chk("covchg_irq", m_irq, 1);
      chk("covchg_fire", m_fire, 4);
      m_disable();

      // watchdog: cov changes every cycle, fires at RUN cycle 5000
      m_enter_run(30'd100);
      for (int i = 0; i < 5000; i++) begin
         m_cov = m_cov + 30'd1;
         step(1);
      end
      chk("wdog_pre_irq", m_irq, 0);
      chk("wdog_stall_zero", m_stall, 0);
      m_cov = m_cov + 30'd1;
      step(1);
      chk("wdog_irq", m_irq, 1);
      chk("wdog_cause", m_cause, 2'b10);
      chk("wdog_fire", m_fire, 5);
      m_ack = 1'b1;
      step(1);
      m_ack = 1'b0;
      chk("wdog_ack", m_irq, 0);
      m_disable();

      // watchdog held off by tohost pulses every 4000 cycles
      m_enter_run(30'd7);
      saw_irq = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         m_cov    = m_cov + 30'd1;
         m_tohost = ((i % 4000) == 3999) ? 64'd1 : 64'd0;
         step(1);
         if (m_irq) saw_irq = 1'b1;
      end
      m_tohost = 64'd0;
      chk("wdog_never", saw_irq, 0);
      m_disable();

      // reset while in FIRE
      m_enter_run(30'd0);
      step(1001);
      chk("prereset_irq", m_irq, 1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("fire_rst_irq", m_irq, 0);
      chk("fire_rst_fire", m_fire, 0);
      chk("fire_rst_cause", m_cause, 0);
      chk("fire_rst_stall", m_stall, 0);
      chk("fire_rst_state", m_state, ST_IDLE);
      m_enable = 1'b0;

      // saturation on the narrow instance: thr clamps to 63, watchdog also 63
      exp_q.push_back(64'd63);
      exp_q.push_back(64'd3);
      s_cov    = 8'hFF;
      s_enable = 1'b1;
      step(1);
      chk("sat_run_entry", s_state, ST_RUN);
      step(63);
      chk("sat_pre_irq", s_irq, 0);
      chk("sat_stall_max", s_stall, exp_q.pop_front());
      step(1);
      chk("sat_irq", s_irq, 1);
      chk("sat_cause_both", s_cause, exp_q.pop_front());
      chk("sat_fire", s_fire, 1);
      chk("sat_stall_held", s_stall, 63);
      s_enable = 1'b0;
      step(1);
      chk("sat_disable", s_irq, 0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
